// File: rtl/vout_slew_pwm.sv
// Slew-limited PWM duty generator with soft start and filtered overvoltage trip.
// Duty is only updated on PWM period boundaries, except for forced shutdown.
module vout_slew_pwm #(
    parameter int STEP     = 4,
    parameter int OV_LIMIT = 240,
    parameter int OV_CNT   = 4,
    parameter int RETRY    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] vin_req,
    output logic       pwm,
    output logic [7:0] duty,
    output logic       period_tick,
    output logic       fault,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RAMP  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [7:0] STEP_U     = 8'(STEP);
    localparam logic [7:0] OV_LIMIT_U = 8'(OV_LIMIT);
    localparam logic [3:0] OV_CNT_U   = 4'(OV_CNT);
    localparam logic [7:0] RETRY_U    = 8'(RETRY);

    // Move cur toward tgt by at most STEP; the difference is taken in the
    // direction that cannot underflow, so the result never wraps.
    function automatic logic [7:0] slew_to(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return (diff <= STEP_U) ? tgt : cur + STEP_U;
        end else begin
            diff = cur - tgt;
            return (diff <= STEP_U) ? tgt : cur - STEP_U;
        end
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] duty_q, duty_d;
    logic [3:0] ov_q, ov_d;
    logic [7:0] ret_q, ret_d;
    logic [1:0] state_q, state_d;

    logic       boundary;
    logic       active;
    logic       ov_hit;
    logic [3:0] ov_inc;
    logic [7:0] slew_val;
    logic       trip;

    always_comb begin
        boundary = (cnt_q == 8'hFF);
        active   = (state_q == S_RAMP) || (state_q == S_RUN);
        ov_hit   = (vin_req > OV_LIMIT_U);
        ov_inc   = sat_inc4(ov_q);
        slew_val = slew_to(duty_q, vin_req);
        trip     = active && boundary && ov_hit && (ov_inc >= OV_CNT_U);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority in the active states: trip, then shutdown, then slewing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_RAMP;
            end
            S_RAMP, S_RUN: begin
                if (trip) begin
                    state_d = S_FAULT;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else if (boundary && (state_q == S_RAMP) && (slew_val == vin_req)) begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: begin
                if (boundary && (ret_q == 8'd1)) state_d = enable ? S_RAMP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q + 8'd1;
        duty_d = duty_q;
        ov_d   = ov_q;
        ret_d  = ret_q;
        case (state_q)
            S_RAMP, S_RUN: begin
                if (trip) begin
                    duty_d = 8'd0;
                    ov_d   = 4'd0;
                    ret_d  = RETRY_U;
                end else if (!enable) begin
                    duty_d = 8'd0;
                    ov_d   = 4'd0;
                end else if (boundary) begin
                    duty_d = slew_val;
                    ov_d   = ov_hit ? ov_inc : 4'd0;
                end
            end
            S_FAULT: begin
                duty_d = 8'd0;
                ov_d   = 4'd0;
                if (boundary) ret_d = ret_q - 8'd1;
            end
            default: begin
                duty_d = 8'd0;
                ov_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            duty_q <= 8'd0;
            ov_q   <= 4'd0;
            ret_q  <= 8'd0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            ov_q   <= ov_d;
            ret_q  <= ret_d;
        end
    end

    // Outputs decode registers only, so inputs never reach pwm directly.
    always_comb begin
        pwm         = (cnt_q < duty_q);
        duty        = duty_q;
        period_tick = boundary;
        fault       = (state_q == S_FAULT);
        state       = state_q;
    end

endmodule

// File: tb/tb_vout_slew_pwm.sv
// Bench for vout_slew_pwm: boundary-by-boundary vector table with a scoreboard
// queue, plus hand sequences for PWM shape, enable drop and async reset.
module tb_vout_slew_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] vin_req;
    logic       pwm;
    logic [7:0] duty;
    logic       period_tick;
    logic       fault;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] vin;
        logic [7:0] duty;
        logic [1:0] state;
        logic       fault;
    } vec_t;

    typedef struct {
        logic [7:0] duty;
        logic [1:0] state;
        logic       fault;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    vout_slew_pwm #(.STEP(4), .OV_LIMIT(240), .OV_CNT(4), .RETRY(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .vin_req(vin_req),
        .pwm(pwm),
        .duty(duty),
        .period_tick(period_tick),
        .fault(fault),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input int v, input int d, input int s, input int f);
        vec_t r;
        r.vin   = 8'(v);
        r.duty  = 8'(d);
        r.state = 2'(s);
        r.fault = 1'(f);
        tbl.push_back(r);
    endtask

    // Returns at the falling edge just after the next period boundary.
    task automatic next_boundary();
        int n = 0;
        @(negedge clk);
        while (!period_tick && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!period_tick) begin
            errors++;
            $display("FAIL tick_timeout actual=0 expected=1");
        end
        @(negedge clk);
    endtask

    task automatic run_vectors(input int lo, input int hi, input string tag);
        exp_t e;
        exp_t x;
        for (int i = lo; i < hi; i++) begin
            vin_req = tbl[i].vin;
            x.duty  = tbl[i].duty;
            x.state = tbl[i].state;
            x.fault = tbl[i].fault;
            sb.push_back(x);
            next_boundary();
            if (sb.size() == 0) begin
                chk($sformatf("%s[%0d].sb_empty", tag, i), 0, 1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s[%0d].duty", tag, i), int'(duty), int'(e.duty));
                chk($sformatf("%s[%0d].state", tag, i), int'(state), int'(e.state));
                chk($sformatf("%s[%0d].fault", tag, i), int'(fault), int'(e.fault));
            end
        end
    endtask

    initial begin
        int s_soft, s_track, s_ov, s_filt, s_ramp20, s_reen, s_run8, s_end;
        int hi_cnt, tick_cnt, n;

        // Vector table: {vin_req, expected duty, state, fault} per boundary.
        s_soft = tbl.size();
        for (int i = 1; i <= 10; i++) add(40, 4 * i, (i == 10) ? 2 : 1, 0);
        s_track = tbl.size();
        add(42, 42, 2, 0);
        add(30, 38, 2, 0);
        add(30, 34, 2, 0);
        add(30, 30, 2, 0);
        s_ov = tbl.size();
        add(250, 204, 2, 0);
        add(250, 208, 2, 0);
        add(250, 212, 2, 0);
        add(250, 0, 3, 1);
        add(40, 0, 3, 1);
        add(40, 0, 3, 1);
        add(40, 0, 3, 1);
        add(40, 0, 1, 0);
        add(40, 4, 1, 0);
        s_filt = tbl.size();
        add(250, 8, 1, 0);
        add(250, 12, 1, 0);
        add(250, 16, 1, 0);
        add(100, 20, 1, 0);
        add(250, 24, 1, 0);
        add(250, 28, 1, 0);
        add(250, 32, 1, 0);
        s_ramp20 = tbl.size();
        for (int i = 1; i <= 5; i++) add(100, 4 * i, 1, 0);
        s_reen = tbl.size();
        add(100, 4, 1, 0);
        s_run8 = tbl.size();
        add(8, 8, 2, 0);
        s_end = tbl.size();

        rst_n   = 1'b0;
        enable  = 1'b0;
        vin_req = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.pwm", int'(pwm), 0);
        chk("rst.duty", int'(duty), 0);
        chk("rst.state", int'(state), 0);
        chk("rst.fault", int'(fault), 0);
        chk("rst.tick", int'(period_tick), 0);

        // Soft start
        rst_n   = 1'b1;
        enable  = 1'b1;
        vin_req = 8'd40;
        @(negedge clk);
        chk("soft.state_ramp", int'(state), 1);
        chk("soft.duty0", int'(duty), 0);
        run_vectors(s_soft, s_track, "soft");

        hi_cnt   = 0;
        tick_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm) hi_cnt++;
            if (period_tick) tick_cnt++;
            @(negedge clk);
        end
        chk("pwm.high_cycles", hi_cnt, 40);
        chk("pwm.ticks", tick_cnt, 1);

        run_vectors(s_track, s_ov, "track");

        vin_req = 8'd200;
        n = 0;
        while (duty != 8'd200 && n < 60) begin
            next_boundary();
            n++;
        end
        chk("reach200.duty", int'(duty), 200);
        chk("reach200.state", int'(state), 2);

        run_vectors(s_ov, s_filt, "ovtrip");
        run_vectors(s_filt, s_ramp20, "ovfilt");

        // Shut down, then ramp again to duty 20 for the enable-drop case.
        enable  = 1'b0;
        vin_req = 8'd100;
        @(negedge clk);
        chk("off.state", int'(state), 0);
        chk("off.duty", int'(duty), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("on.state", int'(state), 1);
        run_vectors(s_ramp20, s_reen, "ramp20");

        repeat (10) @(negedge clk);
        chk("drop.pwm_before", int'(pwm), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("drop.duty", int'(duty), 0);
        chk("drop.pwm", int'(pwm), 0);
        chk("drop.state", int'(state), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("reen.state", int'(state), 1);
        chk("reen.duty", int'(duty), 0);
        run_vectors(s_reen, s_run8, "reen");
        run_vectors(s_run8, s_end, "run8");

        // Async reset while driving high in RUN
        chk("areset.pwm_before", int'(pwm), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.pwm", int'(pwm), 0);
        chk("areset.duty", int'(duty), 0);
        chk("areset.state", int'(state), 0);
        chk("areset.fault", int'(fault), 0);

        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vout_slew_pwm.md
Name: vout_slew_pwm

Overview:
Downstream stage of the power converter. It takes the converter's registered 8-bit output-voltage request and turns it into a slew-limited PWM duty with soft-start and overvoltage protection. The result is a single-bit PWM drive to the output stage plus status. Duty changes only on PWM period boundaries, so the drive never glitches mid-period.

Parameters:
STEP, 4, max duty change per PWM period (1..255)
OV_LIMIT, 240, vin_req strictly above this counts as an overvoltage sample
OV_CNT, 4, consecutive overvoltage samples that trip a fault (1..15)
RETRY, 4, PWM periods spent in FAULT before leaving it (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  run request; level-sensitive
vin_req  in  8  requested output voltage/duty, from power converter uo_out
pwm  out  1  PWM drive, high while pwm_cnt < duty
duty  out  8  currently applied duty setpoint
period_tick  out  1  high during the cycle where pwm_cnt==255
fault  out  1  high while in FAULT
state  out  2  FSM state: 0 IDLE, 1 RAMP, 2 RUN, 3 FAULT

Behaviour:
- Reset (async, rst_n=0): pwm_cnt=0, duty=0, ov_cnt=0, ret_cnt=0, state=IDLE. Outputs are then pwm=0, period_tick=0, fault=0, state=0.
- pwm_cnt: 8-bit free-running counter, +1 every clk, wraps 255->0, in all states.
- "Boundary" is the clock edge where pwm_cnt goes 255->0; period_tick=1 in the cycle before that edge.
- pwm = (pwm_cnt < duty), decoded from registers only; no combinational path from inputs.
  - duty=0 -> pwm constantly 0.
  - duty=N -> high for exactly N of every 256 cycles, starting at pwm_cnt=0.
- vin_req is sampled only at boundaries. Outside the rules below, duty changes only at boundaries.
- Slew rule (RAMP/RUN, at boundary): d = vin_req - duty.
  - |d| <= STEP -> duty = vin_req.
  - Otherwise duty moves STEP toward vin_req.
  - Arithmetic is unsigned with no wrap: duty stays within 0..255.
- OV filter (at boundary, RAMP/RUN only):
  - vin_req > OV_LIMIT -> ov_cnt+1 (saturating); otherwise ov_cnt=0.
  - When the increment reaches OV_CNT, a trip occurs.
  - ov_cnt is held at 0 in IDLE and FAULT.
- FSM, priority at any edge is trip > enable=0 > slew:
  - IDLE: duty=0. enable=1 -> RAMP on the next edge (need not be a boundary).
  - RAMP: slew at each boundary. If post-update duty == vin_req -> RUN at that same boundary.
  - RUN: continues slewing to track vin_req at boundaries. Stays RUN even while tracking.
  - Any state except FAULT with enable=0 -> IDLE on the next edge, duty=0 immediately (may be mid-period; the forced shutdown glitch is intended).
  - Trip (RAMP/RUN boundary) -> FAULT. On the same edge: duty=0, ret_cnt=RETRY, ov_cnt=0.
  - FAULT: duty held 0, fault=1, ret_cnt decrements at each boundary, enable ignored. At the boundary where ret_cnt goes 1->0: enable=1 -> RAMP with duty=0, else IDLE. fault=0 from that edge.
- Re-entering RAMP always starts from duty=0 (soft start).
- Reset mid-operation: immediate return to reset values; pwm drops the same instant.

Test Plan:
- Soft start: reset, vin_req=40, enable=1.
  - Required: state=RAMP next edge; duty 4,8,..,40 over 10 boundaries; state=RUN at the 10th.
  - Then pwm high for exactly 40 of 256 cycles; period_tick every 256 cycles.
- Tracking: in RUN at duty=40, vin_req=42 -> duty=42 at the next boundary (|d|<=STEP). Then vin_req=30 -> duty 38,34,30; state stays RUN.
- OV trip: RUN at duty=200, vin_req=250.
  - Boundaries 1-3: duty 204,208,212.
  - Boundary 4: duty=0, fault=1, state=3.
  - With enable held 1, 4 boundaries later: state=RAMP, fault=0, duty=0, then ramps +4/period.
- OV filter: vin_req sequence over boundaries 250,250,250,100,250,250,250 -> no trip; fault stays 0.
- Enable drop: mid-RAMP at duty=20, mid-period, enable=0 -> next edge duty=0, pwm=0, state=IDLE. Re-enable ramps from 4.
- Async reset: assert rst_n=0 while pwm=1 in RUN -> pwm, duty, state, fault all 0 without waiting for clk.
